// File: rtl/sys_array_loader.sv
// sys_array_loader: streams W and B into the fetcher's parallel buses, sequences it,
// and streams the captured result matrix back out row-major with a last marker.
`default_nettype none

module sys_array_loader #(
  parameter int DATA_WIDTH     = 8,
  parameter int ARRAY_W_W      = 2,
  parameter int ARRAY_W_L      = 5,
  parameter int ARRAY_A_W      = 5,
  parameter int ARRAY_A_L      = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [DATA_WIDTH-1:0]                         in_data,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  output logic [2*DATA_WIDTH-1:0]                       out_data,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic                                          out_last,
  output logic                                          busy,
  output logic                                          error,
  output logic                                          fetch_reset_n,
  output logic                                          fetch_load_params,
  output logic                                          fetch_start_comp,
  output logic [ARRAY_A_W*ARRAY_A_L*DATA_WIDTH-1:0]     fetch_data_b,
  output logic [ARRAY_W_W*ARRAY_W_L*DATA_WIDTH-1:0]     fetch_data_w,
  input  logic                                          fetch_ready,
  input  logic [ARRAY_W_W*ARRAY_A_L*2*DATA_WIDTH-1:0]   fetch_result
);

  localparam int NW  = ARRAY_W_W * ARRAY_W_L;
  localparam int NB  = ARRAY_A_W * ARRAY_A_L;
  localparam int NR  = ARRAY_W_W * ARRAY_A_L;
  localparam int NIN = NW + NB;
  localparam int RW  = 2 * DATA_WIDTH;
  localparam int CW  = $clog2(NIN + 1);
  localparam int OW  = $clog2(NR + 1);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_RECV  = 3'd0,
    S_CLR   = 3'd1,
    S_LOAD  = 3'd2,
    S_START = 3'd3,
    S_WAIT  = 3'd4,
    S_SEND  = 3'd5
  } state_t;

  state_t              state, next_state;
  logic [CW-1:0]       in_cnt;
  logic [OW-1:0]       out_idx;
  logic [TW-1:0]       tcnt;
  logic [NW*DATA_WIDTH-1:0] w_mat;
  logic [NB*DATA_WIDTH-1:0] b_mat;
  logic [NR*RW-1:0]    result;
  logic                load_params_q, start_comp_q, error_q;

  logic accept, last_in, out_fire, last_out, timeout;

  assign accept   = in_valid && in_ready;
  assign last_in  = accept && (in_cnt == CW'(NIN - 1));
  assign out_fire = out_valid && out_ready;
  assign last_out = out_fire && (out_idx == OW'(NR - 1));
  assign timeout  = (tcnt == TW'(TIMEOUT_CYCLES - 1));

  assign in_ready          = (state == S_RECV);
  assign out_valid         = (state == S_SEND);
  assign out_last          = out_valid && (out_idx == OW'(NR - 1));
  assign busy              = !((state == S_RECV) && (in_cnt == '0));
  assign error             = error_q;
  assign fetch_reset_n     = !(reset || (state == S_CLR));
  assign fetch_load_params = load_params_q;
  assign fetch_start_comp  = start_comp_q;
  assign fetch_data_w      = w_mat;
  assign fetch_data_b      = b_mat;

  always_comb begin
    out_data = '0;
    for (int j = 0; j < NR; j++) begin
      if (out_idx == OW'(j)) out_data = result[j*RW +: RW];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_RECV;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_RECV:  if (last_in) next_state = S_CLR;
      S_CLR:   next_state = S_LOAD;
      S_LOAD:  next_state = S_START;
      S_START: next_state = S_WAIT;
      S_WAIT: begin
        if (fetch_ready)  next_state = S_SEND;
        else if (timeout) next_state = S_RECV;
      end
      S_SEND:  if (last_out) next_state = S_RECV;
      default: next_state = S_RECV;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_cnt        <= '0;
      out_idx       <= '0;
      tcnt          <= '0;
      w_mat         <= '0;
      b_mat         <= '0;
      result        <= '0;
      load_params_q <= 1'b0;
      start_comp_q  <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      // Pulses are registered from the upcoming state so they coincide with LOAD/START.
      load_params_q <= (next_state == S_LOAD);
      start_comp_q  <= (next_state == S_START);
      case (state)
        S_RECV: begin
          if (accept) begin
            if (in_cnt == '0) error_q <= 1'b0;
            for (int k = 0; k < NW; k++) begin
              if (in_cnt == CW'(k)) w_mat[k*DATA_WIDTH +: DATA_WIDTH] <= in_data;
            end
            for (int k = 0; k < NB; k++) begin
              if (in_cnt == CW'(NW + k)) b_mat[k*DATA_WIDTH +: DATA_WIDTH] <= in_data;
            end
            in_cnt <= last_in ? '0 : in_cnt + CW'(1);
          end
        end
        S_WAIT: begin
          if (fetch_ready) begin
            result <= fetch_result;
            tcnt   <= '0;
          end else if (timeout) begin
            error_q <= 1'b1;
            tcnt    <= '0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        S_SEND: begin
          if (out_fire) out_idx <= last_out ? '0 : out_idx + OW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sys_array_loader.sv
// Bench for sys_array_loader: table of jobs with a behavioural fetcher and a result scoreboard.
`default_nettype none

module tb_sys_array_loader;

  localparam int NW  = 10;
  localparam int NIN = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        error;
  logic        fetch_reset_n;
  logic        fetch_load_params;
  logic        fetch_start_comp;
  logic [79:0] fetch_data_b;
  logic [79:0] fetch_data_w;
  logic        fetch_ready;
  logic [63:0] fetch_result;

  always #5 clk = ~clk;

  sys_array_loader dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .error(error),
    .fetch_reset_n(fetch_reset_n), .fetch_load_params(fetch_load_params),
    .fetch_start_comp(fetch_start_comp), .fetch_data_b(fetch_data_b),
    .fetch_data_w(fetch_data_w), .fetch_ready(fetch_ready), .fetch_result(fetch_result)
  );

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int beats    = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic fail(input string nm);
    chk_cnt++;
    $display("FAIL %s: bound expired or unexpected event", nm);
  endtask

  // Behavioural fetcher: result valid 12 cycles after start_comp, cleared by fetch_reset_n.
  logic        f_ready, f_arm, f_never, stale_hi;
  logic [3:0]  f_cnt;
  logic [63:0] f_result;

  function automatic logic [63:0] matmul(input logic [79:0] w, input logic [79:0] b);
    logic [15:0] acc;
    matmul = '0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        acc = '0;
        for (int k = 0; k < 5; k++)
          acc = acc + 16'(w[(i*5+k)*8 +: 8]) * 16'(b[(k*2+j)*8 +: 8]);
        matmul[(i*2+j)*16 +: 16] = acc;
      end
    end
  endfunction

  always @(posedge clk) begin
    if (!fetch_reset_n) begin
      f_ready  <= 1'b0;
      f_arm    <= 1'b0;
      f_cnt    <= '0;
      f_result <= '0;
    end else if (fetch_start_comp) begin
      f_arm <= !f_never;
      f_cnt <= '0;
    end else if (f_arm) begin
      f_cnt <= f_cnt + 4'd1;
      if (f_cnt == 4'd11) begin
        f_ready  <= 1'b1;
        f_arm    <= 1'b0;
        f_result <= matmul(fetch_data_w, fetch_data_b);
      end
    end
  end

  // A stale ready with a poison result must not be sampled outside WAIT.
  assign fetch_ready  = f_ready | stale_hi;
  assign fetch_result = stale_hi ? 64'hBAD0_BAD1_BAD2_BAD3 : f_result;

  typedef struct packed { logic [15:0] d; logic l; } beat_t;
  beat_t sb[$];

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      beats++;
      if (sb.size() == 0) begin
        fail("unexpected_out_beat");
      end else begin
        beat_t e;
        e = sb.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_last", out_last, e.l);
      end
    end
  end

  typedef struct {
    logic [7:0]  wb, ws, bb, bs;
    logic [15:0] e [4];
  } vec_t;
  vec_t tbl [4];

  function automatic logic [7:0] elem(input vec_t v, input int k);
    if (k < NW) return 8'(v.wb + v.ws * 8'(k));
    return 8'(v.bb + v.bs * 8'(k - NW));
  endfunction

  task automatic send_job(input vec_t v, input bit gap, input bit stall, input bit stale,
                          input bit expect_out);
    bit acc;
    int g, n, stall_left;
    beats = 0;
    stall_left = stall ? 3 : 0;
    stale_hi = stale;
    if (expect_out)
      for (int j = 0; j < 4; j++) sb.push_back('{d: v.e[j], l: (j == 3)});
    for (int k = 0; k < NIN; k++) begin
      in_data = elem(v, k);
      in_valid = 1'b1;
      acc = 1'b0;
      g = 0;
      while (!acc && g < 50) begin
        @(negedge clk); acc = in_ready;
        @(posedge clk); #1; g++;
      end
      if (!acc) fail("in_accept");
      in_valid = 1'b0;
      in_data = 8'hEE;
      if (k == 0) begin
        chk("error_cleared_first_elem", error, 0);
        chk("busy_after_first", busy, 1);
      end
      if (gap && k != NIN-1) begin @(posedge clk); #1; end
    end
    // Control sequence, with junk presented on the input that must be ignored.
    in_valid = 1'b1;
    chk("clr_reset_n", fetch_reset_n, 0);
    chk("clr_in_ready", in_ready, 0);
    chk("clr_load", fetch_load_params, 0);
    @(posedge clk); #1;
    chk("load_reset_n", fetch_reset_n, 1);
    chk("load_pulse", fetch_load_params, 1);
    chk("load_start", fetch_start_comp, 0);
    @(posedge clk); #1;
    chk("start_load", fetch_load_params, 0);
    chk("start_pulse", fetch_start_comp, 1);
    @(posedge clk); #1;
    chk("wait_start", fetch_start_comp, 0);
    chk("wait_in_ready", in_ready, 0);
    in_valid = 1'b0;
    stale_hi = 1'b0;
    if (expect_out) begin
      n = 0;
      while (sb.size() != 0 && n < 300) begin
        @(posedge clk); #1; n++;
        if (stall_left > 0 && beats == 2 && out_valid) begin
          out_ready = 1'b0;
          stall_left--;
          @(negedge clk);
          chk("stall_valid", out_valid, 1);
          chk("stall_data", out_data, sb[0].d);
          chk("stall_last", out_last, 0);
        end else begin
          out_ready = 1'b1;
        end
      end
      out_ready = 1'b1;
      chk("sb_drained", sb.size(), 0);
      chk("end_in_ready", in_ready, 1);
      chk("end_out_valid", out_valid, 0);
      chk("end_busy", busy, 0);
    end else begin
      n = 0;
      while (!error && n < 100) begin @(posedge clk); #1; n++; end
      chk("timeout_cycles", n, 64);
      chk("timeout_in_ready", in_ready, 1);
      chk("timeout_busy", busy, 0);
      chk("timeout_no_beats", beats, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{wb: 8'd1,   ws: 8'd0, bb: 8'd1,   bs: 8'd1, e: '{16'd25, 16'd30, 16'd25, 16'd30}};
    tbl[1] = '{wb: 8'd1,   ws: 8'd1, bb: 8'd2,   bs: 8'd0, e: '{16'd30, 16'd30, 16'd80, 16'd80}};
    tbl[2] = '{wb: 8'd3,   ws: 8'd0, bb: 8'd0,   bs: 8'd1, e: '{16'd60, 16'd75, 16'd60, 16'd75}};
    // 5*255*255 = 325125, mod 2^16 = 62981
    tbl[3] = '{wb: 8'd255, ws: 8'd0, bb: 8'd255, bs: 8'd0, e: '{16'd62981, 16'd62981, 16'd62981, 16'd62981}};

    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    f_never = 1'b0; stale_hi = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_error", error, 0);
    chk("rst_load", fetch_load_params, 0);
    chk("rst_start", fetch_start_comp, 0);
    chk("rst_fetch_reset_n", fetch_reset_n, 0);
    chk("rst_data_w", fetch_data_w, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_fetch_reset_n", fetch_reset_n, 1);

    for (int i = 0; i < 4; i++) send_job(tbl[i], 1'b0, 1'b0, 1'b0, 1'b1);

    send_job(tbl[0], 1'b1, 1'b1, 1'b0, 1'b1);
    send_job(tbl[1], 1'b0, 1'b0, 1'b1, 1'b1);

    f_never = 1'b1;
    send_job(tbl[0], 1'b0, 1'b0, 1'b0, 1'b0);
    f_never = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("error_sticky", error, 1);
    send_job(tbl[2], 1'b0, 1'b0, 1'b0, 1'b1);

    for (int k = 0; k < 7; k++) begin
      in_data = elem(tbl[3], k);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("partial_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_fetch_reset_n", fetch_reset_n, 0);
    @(posedge clk); #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 1);
    reset = 1'b0;
    @(posedge clk); #1;
    send_job(tbl[2], 1'b0, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

`default_nettype wire
